// File: rtl/rf_pkg.sv
// Shared FunSel encodings and the register next-value function for param_register_file.
package rf_pkg;

  localparam int unsigned RF_MAX_W = 64;

  typedef logic [2:0]          funsel_t;
  typedef logic [RF_MAX_W-1:0] rf_word_t;

  localparam funsel_t FS_DEC  = 3'b000;
  localparam funsel_t FS_INC  = 3'b001;
  localparam funsel_t FS_LOAD = 3'b010;
  localparam funsel_t FS_CLR  = 3'b011;
  localparam funsel_t FS_LDB0 = 3'b100;
  localparam funsel_t FS_LDBK = 3'b101;
  localparam funsel_t FS_LDHS = 3'b110;
  localparam funsel_t FS_HOLD = 3'b111;

  // Evaluated at RF_MAX_W and truncated by the caller; every operation is
  // modular or byte-aligned, so truncation yields the WIDTH-bit result.
  function automatic rf_word_t next_q(input rf_word_t q, input rf_word_t i, input funsel_t funsel);
    rf_word_t r;
    case (funsel)
      FS_DEC:  r = q - rf_word_t'(1);
      FS_INC:  r = q + rf_word_t'(1);
      FS_LOAD: r = i;
      FS_CLR:  r = '0;
      FS_LDB0: r = {{(RF_MAX_W-8){1'b0}}, i[7:0]};
      FS_LDBK: r = {q[RF_MAX_W-1:8], i[7:0]};
      FS_LDHS: r = {{(RF_MAX_W-16){i[15]}}, i[15:0]};
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rf_cell.sv
// One register of the file: async-reset storage with enable and FunSel update,
// exposing both the current value and the value it will take at the next edge.
module rf_cell
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  funsel_t          funsel,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;
  rf_word_t         q_ext;
  rf_word_t         i_ext;

  always_comb begin
    q_ext              = '0;
    q_ext[WIDTH-1:0]   = val_q;
    i_ext              = '0;
    i_ext[WIDTH-1:0]   = d_in;
    val_d              = val_q;
    if (en) begin
      val_d = WIDTH'(next_q(q_ext, i_ext, funsel));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q      = val_q;
  assign q_next = val_d;

endmodule

// File: rtl/param_register_file.sv
// NUM_GP general-purpose plus NUM_SCR scratch registers on one shared input bus,
// with two registered read ports and optional write-bypass.
module param_register_file
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_GP  = 4,
  parameter int unsigned NUM_SCR = 4,
  parameter int unsigned BYPASS  = 0,
  parameter int unsigned SEL_W   = $clog2(NUM_GP + NUM_SCR)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   i,
  input  logic [NUM_GP-1:0]  RegSel,
  input  logic [NUM_SCR-1:0] ScrSel,
  input  logic [2:0]         FunSel,
  input  logic [SEL_W-1:0]   OutASel,
  input  logic [SEL_W-1:0]   OutBSel,
  output logic [WIDTH-1:0]   OutA,
  output logic [WIDTH-1:0]   OutB
);

  localparam int unsigned NUM_REGS  = NUM_GP + NUM_SCR;
  localparam int unsigned SEL_DEPTH = 1 << SEL_W;

  logic [NUM_REGS-1:0] en;
  logic [WIDTH-1:0]    cur    [NUM_REGS];
  logic [WIDTH-1:0]    nxt    [NUM_REGS];
  logic [WIDTH-1:0]    rd_src [SEL_DEPTH];

  logic [WIDTH-1:0] outa_q;
  logic [WIDTH-1:0] outa_d;
  logic [WIDTH-1:0] outb_q;
  logic [WIDTH-1:0] outb_d;

  // Select masks are MSB-first (MSB = R1 / S1); the cell array is index-first.
  for (genvar g = 0; g < NUM_GP; g++) begin : g_gp_en
    assign en[g] = RegSel[NUM_GP-1-g];
  end

  for (genvar g = 0; g < NUM_SCR; g++) begin : g_scr_en
    assign en[NUM_GP+g] = ScrSel[NUM_SCR-1-g];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    rf_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk    (clock),
      .rst    (reset),
      .en     (en[g]),
      .funsel (FunSel),
      .d_in   (i),
      .q      (cur[g]),
      .q_next (nxt[g])
    );
  end

  // Read table padded to the full select range; unused slots read as zero,
  // which is the out-of-range behaviour without a separate compare.
  for (genvar g = 0; g < SEL_DEPTH; g++) begin : g_rd_src
    if (g < NUM_REGS) begin : g_valid
      assign rd_src[g] = (BYPASS != 0) ? nxt[g] : cur[g];
    end else begin : g_pad
      assign rd_src[g] = '0;
    end
  end

  always_comb begin
    outa_d = rd_src[OutASel];
    outb_d = rd_src[OutBSel];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outa_q <= '0;
      outb_q <= '0;
    end else begin
      outa_q <= outa_d;
      outb_q <= outb_d;
    end
  end

  assign OutA = outa_q;
  assign OutB = outb_q;

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file: default, bypass and a small 16-bit 3+2 configuration.
module tb_param_register_file;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit 4+4 instances (BYPASS 0 and 1) share stimulus
  logic [31:0] i_w;
  logic [3:0]  reg_sel, scr_sel;
  logic [2:0]  fs, a_sel, b_sel;
  logic [31:0] oa0, ob0, oa1, ob1;

  // 16-bit 3+2 instance
  logic [15:0] i_s;
  logic [2:0]  reg_sel_s;
  logic [1:0]  scr_sel_s;
  logic [2:0]  fs_s, a_sel_s, b_sel_s;
  logic [15:0] oa2, ob2;

  param_register_file #(.WIDTH(32), .NUM_GP(4), .NUM_SCR(4), .BYPASS(0)) d0 (
    .clock(clk), .reset(rst), .i(i_w), .RegSel(reg_sel), .ScrSel(scr_sel), .FunSel(fs),
    .OutASel(a_sel), .OutBSel(b_sel), .OutA(oa0), .OutB(ob0));

  param_register_file #(.WIDTH(32), .NUM_GP(4), .NUM_SCR(4), .BYPASS(1)) d1 (
    .clock(clk), .reset(rst), .i(i_w), .RegSel(reg_sel), .ScrSel(scr_sel), .FunSel(fs),
    .OutASel(a_sel), .OutBSel(b_sel), .OutA(oa1), .OutB(ob1));

  param_register_file #(.WIDTH(16), .NUM_GP(3), .NUM_SCR(2), .BYPASS(0)) d2 (
    .clock(clk), .reset(rst), .i(i_s), .RegSel(reg_sel_s), .ScrSel(scr_sel_s), .FunSel(fs_s),
    .OutASel(a_sel_s), .OutBSel(b_sel_s), .OutA(oa2), .OutB(ob2));

  int n_total = 0;
  int n_pass  = 0;

  // Reference state: register contents as plain numbers, R1.. first then S1..
  logic [31:0] m_big   [8];
  logic [15:0] m_small [5];

  typedef struct {
    logic [3:0]  rs;
    logic [3:0]  ss;
    logic [2:0]  f;
    logic [31:0] d;
    logic [2:0]  sel;
    logic [31:0] ea0;
    logic [31:0] ea1;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] q, input logic [31:0] d,
                                            input logic [2:0] f, input int w);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (f)
      3'd0: r = q - 32'd1;
      3'd1: r = q + 32'd1;
      3'd2: r = d;
      3'd3: r = 32'd0;
      3'd4: r = d % 32'd256;
      3'd5: r = (q - (q % 32'd256)) + (d % 32'd256);
      3'd6: begin
        r = d % 32'd65536;
        if (r >= 32'd32768) r = r - 32'd65536;
      end
      default: r = q;
    endcase
    return r & mask;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_big[k] = '0;
    for (int k = 0; k < 5; k++) m_small[k] = '0;
  endtask

  // One clock edge: predict from the reference, then compare all six outputs.
  task automatic step();
    logic [31:0] nb [8];
    logic [15:0] ns [5];
    logic [31:0] e0a, e0b, e1a, e1b;
    logic [15:0] e2a, e2b;
    logic en;
    for (int k = 0; k < 8; k++) begin
      en = (k < 4) ? reg_sel[3-k] : scr_sel[7-k];
      nb[k] = en ? ref_next(m_big[k], i_w, fs, 32) : m_big[k];
    end
    for (int k = 0; k < 5; k++) begin
      en = (k < 3) ? reg_sel_s[2-k] : scr_sel_s[4-k];
      ns[k] = en ? 16'(ref_next({16'h0, m_small[k]}, {16'h0, i_s}, fs_s, 16)) : m_small[k];
    end
    e0a = m_big[a_sel]; e0b = m_big[b_sel];
    e1a = nb[a_sel];    e1b = nb[b_sel];
    if (a_sel_s < 3'd5) e2a = m_small[a_sel_s]; else e2a = '0;
    if (b_sel_s < 3'd5) e2b = m_small[b_sel_s]; else e2b = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) m_big[k] = nb[k];
    for (int k = 0; k < 5; k++) m_small[k] = ns[k];
    check("oa0", oa0, e0a);
    check("ob0", ob0, e0b);
    check("oa1", oa1, e1a);
    check("ob1", ob1, e1b);
    check("oa2", {16'h0, oa2}, {16'h0, e2a});
    check("ob2", {16'h0, ob2}, {16'h0, e2b});
  endtask

  task automatic idle_inputs();
    i_w = '0; reg_sel = '0; scr_sel = '0; fs = 3'b111; a_sel = '0; b_sel = '0;
    i_s = '0; reg_sel_s = '0; scr_sel_s = '0; fs_s = 3'b111; a_sel_s = '0; b_sel_s = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{4'b0100, 4'b0000, 3'd2, 32'hAABBCCDD, 3'd1, 32'h00000000, 32'hAABBCCDD};
    tbl[1] = '{4'b0100, 4'b0000, 3'd5, 32'h00000011, 3'd1, 32'hAABBCCDD, 32'hAABBCC11};
    tbl[2] = '{4'b0100, 4'b0000, 3'd4, 32'h00000022, 3'd1, 32'hAABBCC11, 32'h00000022};
    tbl[3] = '{4'b0100, 4'b0000, 3'd6, 32'h00008001, 3'd1, 32'h00000022, 32'hFFFF8001};
    tbl[4] = '{4'b0000, 4'b0000, 3'd7, 32'h00000000, 3'd1, 32'hFFFF8001, 32'hFFFF8001};
    tbl[5] = '{4'b0000, 4'b1000, 3'd3, 32'h00000000, 3'd4, 32'h00000000, 32'h00000000};
    tbl[6] = '{4'b0000, 4'b1000, 3'd0, 32'h00000000, 3'd4, 32'h00000000, 32'hFFFFFFFF};
    tbl[7] = '{4'b0000, 4'b1000, 3'd1, 32'h00000000, 3'd4, 32'hFFFFFFFF, 32'h00000000};
    tbl[8] = '{4'b0000, 4'b0000, 3'd7, 32'h00000000, 3'd4, 32'h00000000, 32'h00000000};

    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_oa0", oa0, 32'h0);
    check("rst_ob0", ob0, 32'h0);
    check("rst_oa1", oa1, 32'h0);
    check("rst_ob1", ob1, 32'h0);
    check("rst_oa2", {16'h0, oa2}, 32'h0);
    check("rst_ob2", {16'h0, ob2}, 32'h0);
    rst = 1'b0;

    // LOAD latency, both bypass settings
    reg_sel = 4'b1000; fs = 3'd2; i_w = 32'hDEADBEEF; a_sel = 3'd0; b_sel = 3'd0;
    step();
    check("lat_nobyp_first", oa0, 32'h0);
    check("lat_byp_first", oa1, 32'hDEADBEEF);
    reg_sel = 4'b0000; fs = 3'd7;
    step();
    check("lat_nobyp_second", oa0, 32'hDEADBEEF);

    // Asynchronous reset in the middle of a cycle
    reg_sel = 4'b1000; fs = 3'd2; i_w = 32'h00001234;
    step();
    reg_sel = 4'b0000; fs = 3'd7;
    step();
    check("pre_rst_r1", oa0, 32'h00001234);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_oa0", oa0, 32'h0);
    check("async_rst_ob0", ob0, 32'h0);
    check("async_rst_oa1", oa1, 32'h0);
    check("async_rst_ob1", ob1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a_sel = 3'(k); b_sel = 3'(7 - k);
      step();
    end

    // Directed table: R2 partial loads, S1 wrap
    for (int v = 0; v < 9; v++) begin
      reg_sel = tbl[v].rs; scr_sel = tbl[v].ss; fs = tbl[v].f; i_w = tbl[v].d;
      a_sel = tbl[v].sel; b_sel = tbl[v].sel;
      step();
      check($sformatf("tbl%0d_oa0", v), oa0, tbl[v].ea0);
      check($sformatf("tbl%0d_ob0", v), ob0, tbl[v].ea0);
      check($sformatf("tbl%0d_oa1", v), oa1, tbl[v].ea1);
    end

    // Multi-enable LOAD then HOLD with every register enabled
    reg_sel = 4'b1111; scr_sel = 4'b1111; fs = 3'd2; i_w = 32'h5; a_sel = 3'd7; b_sel = 3'd3;
    step();
    fs = 3'd7;
    for (int k = 0; k < 8; k++) begin
      a_sel = 3'(k); b_sel = 3'(k);
      step();
      check($sformatf("multi_a%0d", k), oa0, 32'h5);
      check($sformatf("multi_b%0d", k), ob0, 32'h5);
    end
    for (int c = 0; c < 3; c++) begin
      a_sel = 3'(c); b_sel = 3'(7 - c);
      step();
      check($sformatf("hold_a%0d", c), oa0, 32'h5);
      check($sformatf("hold_b%0d", c), ob1, 32'h5);
    end
    reg_sel = '0; scr_sel = '0;

    // Small configuration: out-of-range selects and 16-bit INC wrap
    reg_sel_s = 3'b111; scr_sel_s = 2'b11; fs_s = 3'd2; i_s = 16'hFFFF;
    step();
    fs_s = 3'd1; a_sel_s = 3'd5; b_sel_s = 3'd3;
    step();
    check("small_oor5", {16'h0, oa2}, 32'h0);
    check("small_s1_pre", {16'h0, ob2}, 32'h0000FFFF);
    fs_s = 3'd7; a_sel_s = 3'd6;
    step();
    check("small_oor6", {16'h0, oa2}, 32'h0);
    check("small_s1_wrap", {16'h0, ob2}, 32'h0);
    a_sel_s = 3'd7; b_sel_s = 3'd0;
    step();
    check("small_oor7", {16'h0, oa2}, 32'h0);
    check("small_r1_wrap", {16'h0, ob2}, 32'h0);
    reg_sel_s = '0; scr_sel_s = '0;

    // Randomized traffic against the reference, with occasional reset pulses
    for (int n = 0; n < 300; n++) begin
      i_w = $urandom; reg_sel = 4'($urandom); scr_sel = 4'($urandom); fs = 3'($urandom);
      a_sel = 3'($urandom); b_sel = 3'($urandom);
      i_s = 16'($urandom); reg_sel_s = 3'($urandom); scr_sel_s = 2'($urandom); fs_s = 3'($urandom);
      a_sel_s = 3'($urandom_range(0, 7)); b_sel_s = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check("rand_rst_oa0", oa0, 32'h0);
        check("rand_rst_ob1", ob1, 32'h0);
        #1;
        rst = 1'b0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
